dtree_seq_eval: RTL and testbench



---
 rtl/dtree_seq_eval.sv | 176 +++++++++++++++++
 tb/tb_dtree_seq_eval.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_seq_eval.sv
// Sequential decision-tree evaluator: walks a register-based node table one node
// per cycle, comparing a shifted feature against a shifted threshold at each node.
//
// state | meaning
// IDLE  | table writable, waiting for a feature vector
// WALK  | evaluating one node per cycle from the root
// DONE  | result held on out_class/out_err until out_ready
module dtree_seq_eval #(
    parameter int N_FEAT    = 4,
    parameter int FW        = 8,
    parameter int N_NODES   = 64,
    parameter int CW        = 2,
    parameter int MAX_DEPTH = 16,
    localparam int AW  = (N_NODES > 1) ? $clog2(N_NODES) : 1,
    localparam int FSW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1,
    localparam int SW  = (FW > 1) ? $clog2(FW) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_FEAT*FW-1:0] in_feat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_class,
    output logic                 out_err,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic                 cfg_leaf,
    input  logic [FSW-1:0]       cfg_feat,
    input  logic [SW-1:0]        cfg_shift,
    input  logic [FW-1:0]        cfg_thr,
    input  logic [AW-1:0]        cfg_left,
    input  logic [AW-1:0]        cfg_right,
    input  logic [CW-1:0]        cfg_class,
    output logic                 cfg_ready
);

    localparam int DW = $clog2(MAX_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                 node_leaf_q  [N_NODES];
    logic [FSW-1:0]       node_feat_q  [N_NODES];
    logic [SW-1:0]        node_shift_q [N_NODES];
    logic [FW-1:0]        node_thr_q   [N_NODES];
    logic [AW-1:0]        node_left_q  [N_NODES];
    logic [AW-1:0]        node_right_q [N_NODES];
    logic [CW-1:0]        node_class_q [N_NODES];

    logic [N_FEAT*FW-1:0] feat_q, feat_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic [DW-1:0]        step_q, step_d;
    logic [CW-1:0]        out_class_q, out_class_d;
    logic                 out_err_q, out_err_d;

    logic                 rd_leaf;
    logic [FSW-1:0]       rd_feat;
    logic [SW-1:0]        rd_shift;
    logic [FW-1:0]        rd_thr;
    logic [AW-1:0]        rd_left;
    logic [AW-1:0]        rd_right;
    logic [CW-1:0]        rd_class;
    logic [FW-1:0]        feat_sel;
    logic                 cmp_le;

    assign cfg_ready = (state_q == IDLE);
    assign in_ready  = (state_q == IDLE) & ~cfg_we;
    assign out_valid = (state_q == DONE);
    assign out_class = out_class_q;
    assign out_err   = out_err_q;

    // Reset restores every node to a class-0 leaf so an unconfigured tree still answers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < N_NODES; n++) begin
                node_leaf_q[n]  <= 1'b1;
                node_feat_q[n]  <= '0;
                node_shift_q[n] <= '0;
                node_thr_q[n]   <= '0;
                node_left_q[n]  <= '0;
                node_right_q[n] <= '0;
                node_class_q[n] <= '0;
            end
        end else if (cfg_we && cfg_ready) begin
            node_leaf_q[cfg_addr]  <= cfg_leaf;
            node_feat_q[cfg_addr]  <= cfg_feat;
            node_shift_q[cfg_addr] <= cfg_shift;
            node_thr_q[cfg_addr]   <= cfg_thr;
            node_left_q[cfg_addr]  <= cfg_left;
            node_right_q[cfg_addr] <= cfg_right;
            node_class_q[cfg_addr] <= cfg_class;
        end
    end

    assign rd_leaf  = node_leaf_q[ptr_q];
    assign rd_feat  = node_feat_q[ptr_q];
    assign rd_shift = node_shift_q[ptr_q];
    assign rd_thr   = node_thr_q[ptr_q];
    assign rd_left  = node_left_q[ptr_q];
    assign rd_right = node_right_q[ptr_q];
    assign rd_class = node_class_q[ptr_q];

    // Out-of-range feature selects read as zero.
    always_comb begin
        feat_sel = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (rd_feat == FSW'(i)) feat_sel = feat_q[i*FW +: FW];
        end
    end

    assign cmp_le = (feat_sel >> rd_shift) <= (rd_thr >> rd_shift);

    always_comb begin
        state_d     = state_q;
        feat_d      = feat_q;
        ptr_d       = ptr_q;
        step_d      = step_q;
        out_class_d = out_class_q;
        out_err_d   = out_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    feat_d  = in_feat;
                    ptr_d   = '0;
                    step_d  = '0;
                    state_d = WALK;
                end
            end
            WALK: begin
                if (rd_leaf) begin
                    out_class_d = rd_class;
                    out_err_d   = 1'b0;
                    state_d     = DONE;
                end else if (step_q == DW'(MAX_DEPTH - 1)) begin
                    out_class_d = '0;
                    out_err_d   = 1'b1;
                    step_d      = step_q + 1'b1;
                    state_d     = DONE;
                end else begin
                    ptr_d  = cmp_le ? rd_left : rd_right;
                    step_d = step_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            feat_q      <= '0;
            ptr_q       <= '0;
            step_q      <= '0;
            out_class_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            feat_q      <= feat_d;
            ptr_q       <= ptr_d;
            step_q      <= step_d;
            out_class_q <= out_class_d;
            out_err_q   <= out_err_d;
        end
    end

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Scoreboard bench for dtree_seq_eval: a behavioural tree walk predicts class,
// error and latency for every accepted vector.
module tb_dtree_seq_eval;

    localparam int N_FEAT = 4, FW = 8, N_NODES = 64, CW = 2, MAX_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_feat = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_class;
    logic        out_err;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic        cfg_leaf = 1'b0;
    logic [1:0]  cfg_feat = '0;
    logic [2:0]  cfg_shift = '0;
    logic [7:0]  cfg_thr = '0;
    logic [5:0]  cfg_left = '0;
    logic [5:0]  cfg_right = '0;
    logic [1:0]  cfg_class = '0;
    logic        cfg_ready;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] cls;
        logic       err;
        int         lat;
    } exp_t;
    exp_t sb[$];

    logic       m_leaf  [N_NODES];
    logic [1:0] m_feat  [N_NODES];
    logic [2:0] m_shift [N_NODES];
    logic [7:0] m_thr   [N_NODES];
    logic [5:0] m_left  [N_NODES];
    logic [5:0] m_right [N_NODES];
    logic [1:0] m_class [N_NODES];

    always #5 clk = ~clk;

    dtree_seq_eval #(.N_FEAT(N_FEAT), .FW(FW), .N_NODES(N_NODES), .CW(CW),
                     .MAX_DEPTH(MAX_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_feat(in_feat), .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_err(out_err), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_leaf(cfg_leaf), .cfg_feat(cfg_feat),
        .cfg_shift(cfg_shift), .cfg_thr(cfg_thr), .cfg_left(cfg_left),
        .cfg_right(cfg_right), .cfg_class(cfg_class), .cfg_ready(cfg_ready)
    );

    function automatic void model_reset();
        for (int n = 0; n < N_NODES; n++) begin
            m_leaf[n] = 1'b1; m_feat[n] = '0; m_shift[n] = '0; m_thr[n] = '0;
            m_left[n] = '0;   m_right[n] = '0; m_class[n] = '0;
        end
    endfunction

    function automatic exp_t model_walk(input logic [31:0] fv);
        exp_t r;
        int   node = 0;
        logic [7:0] x;
        r.cls = '0; r.err = 1'b1; r.lat = MAX_DEPTH;
        for (int step = 0; step < MAX_DEPTH; step++) begin
            if (m_leaf[node]) begin
                r.cls = m_class[node]; r.err = 1'b0; r.lat = step + 1;
                return r;
            end
            x = fv[m_feat[node]*8 +: 8];
            node = ((x >> m_shift[node]) <= (m_thr[node] >> m_shift[node]))
                   ? int'(m_left[node]) : int'(m_right[node]);
        end
        return r;
    endfunction

    task automatic cfg_write(input int a, input logic lf, input int f, input int sh,
                             input int th, input int l, input int r, input int c);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 6'(a); cfg_leaf = lf; cfg_feat = 2'(f);
        cfg_shift = 3'(sh); cfg_thr = 8'(th); cfg_left = 6'(l); cfg_right = 6'(r);
        cfg_class = 2'(c);
        m_leaf[a] = lf; m_feat[a] = 2'(f); m_shift[a] = 3'(sh); m_thr[a] = 8'(th);
        m_left[a] = 6'(l); m_right[a] = 6'(r); m_class[a] = 2'(c);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] fv);
        sb.push_back(model_walk(fv));
        @(negedge clk);
        in_valid = 1'b1; in_feat = fv;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL issue_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_feat = $urandom;
    endtask

    // Waits for the result of the oldest outstanding vector and checks it.
    task automatic collect();
        exp_t e;
        int   lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL result_timeout: no out_valid after %0d edges", lat);
            return;
        end
        n_checks++;
        if (out_class !== e.cls || out_err !== e.err || lat != e.lat) begin
            n_fail++;
            $display("FAIL result: got class=%0d err=%b lat=%0d want class=%0d err=%b lat=%0d",
                     out_class, out_err, lat, e.cls, e.err, e.lat);
        end
        if (out_ready === 1'b1) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_class !== 2'd0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b c=%0d e=%b want 0/0/0", out_valid, out_class, out_err);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got in_ready=%b cfg_ready=%b want 1/1", in_ready, cfg_ready);
        end
    endtask

    task automatic test_unconfigured();
        for (int i = 0; i < 3; i++) begin
            issue($urandom);
            collect();
        end
    endtask

    task automatic test_split();
        cfg_write(0, 1'b0, 0, 6, 'h3F, 1, 2, 0);
        cfg_write(1, 1'b1, 0, 0, 0, 0, 0, 1);
        cfg_write(2, 1'b1, 0, 0, 0, 0, 0, 2);
        issue(32'hFFFF_FF20); collect();
        issue(32'h0000_0040); collect();
        issue(32'h1234_563F); collect();
    endtask

    task automatic test_chain();
        for (int n = 0; n <= 20; n++)
            cfg_write(n, 1'b0, n % 4, 0, 0, (n + 1) % 21, (n + 1) % 21, 3);
        issue($urandom);
        collect();
    endtask

    task automatic test_backpressure();
        logic [1:0] held_c;
        test_split();
        out_ready = 1'b0;
        issue(32'h0000_0040);
        collect();
        held_c = out_class;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_class !== 2'd2 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold: cyc %0d v=%b c=%0d in_ready=%b want 1/2/0",
                         i, out_valid, out_class, in_ready);
            end
        end
        n_checks++;
        if (held_c !== 2'd2) begin
            n_fail++; $display("FAIL backpressure_class: got %0d want 2", held_c);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: got v=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        cfg_write(0, 1'b0, 1, 0, 'h80, 3, 4, 0);
        cfg_write(3, 1'b0, 2, 2, 'h40, 5, 6, 0);
        cfg_write(4, 1'b1, 0, 0, 0, 0, 0, 3);
        cfg_write(5, 1'b1, 0, 0, 0, 0, 0, 1);
        cfg_write(6, 1'b0, 3, 4, 'hA0, 7, 8, 0);
        cfg_write(7, 1'b1, 0, 0, 0, 0, 0, 0);
        cfg_write(8, 1'b1, 0, 0, 0, 0, 0, 2);
        issue(32'h0000_8000); collect();
        issue(32'h0043_8000); collect();
        issue(32'hAF50_0000); collect();
        issue(32'hB000_0000); collect();
        for (int i = 0; i < 8; i++) begin
            issue($urandom);
            collect();
        end
    endtask

    task automatic test_cfg_priority();
        exp_t e;
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_leaf = 1'b1; cfg_class = 2'd3;
        cfg_feat = '0; cfg_shift = '0; cfg_thr = '0; cfg_left = '0; cfg_right = '0;
        m_leaf[0] = 1'b1; m_class[0] = 2'd3; m_feat[0] = '0; m_shift[0] = '0;
        m_thr[0] = '0; m_left[0] = '0; m_right[0] = '0;
        in_valid = 1'b1; in_feat = $urandom;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_priority: got in_ready=%b cfg_ready=%b want 0/1", in_ready, cfg_ready);
        end
        e = model_walk(in_feat);
        sb.push_back(e);
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL cfg_priority_next: got in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        collect();
    endtask

    task automatic test_reset_mid_walk();
        int seen = 0;
        for (int n = 0; n <= 20; n++)
            cfg_write(n, 1'b0, 0, 0, 0, (n + 1) % 21, (n + 1) % 21, 1);
        @(negedge clk);
        in_valid = 1'b1; in_feat = $urandom;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL reset_mid_walk: got %0d out_valid cycles want 0", seen);
        end
        issue($urandom);
        collect();
    endtask

    initial begin
        test_reset();
        test_unconfigured();
        test_split();
        test_chain();
        test_backpressure();
        test_back_to_back();
        test_cfg_priority();
        test_reset_mid_walk();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
